// File: rtl/vec_tx_pkg.sv
// Shared constants and types for the vec_tx_32_16 vector transmitter.
// Covers the word format, the FSM state encoding and the skid entry layout.
package vec_tx_pkg;

    localparam int T       = 16;
    localparam int X_COUNT = 32;
    localparam int ADDR_X  = $clog2(X_COUNT);

    typedef logic signed [T-1:0] word_t;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        PRIME = 2'd1,
        SEND  = 2'd2
    } state_t;

    // One buffered beat: the word plus its end-of-pass marker.
    typedef struct packed {
        logic  last;
        word_t data;
    } beat_t;

endpackage

// File: rtl/vec_tx_skid.sv
// Two-entry skid FIFO on the memory read path.
// It absorbs the one in-flight read when the downstream stalls.
module vec_tx_skid #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] entry [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;

    // Caller guarantees no push into a full FIFO unless it pops in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            entry[0] <= '0;
            entry[1] <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
        end else begin
            if (push) begin
                entry[wr_ptr] <= push_data;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign head  = entry[rd_ptr];
    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);

endmodule

// File: rtl/vec_tx_32_16.sv
// Loads one X_COUNT-word vector, then replays it REPEAT times toward a conv x-input.
// Optional macro VEC_TX_LAST_EN adds m_last_x marking the final word of each pass.
module vec_tx_32_16
    import vec_tx_pkg::*;
#(
    parameter int REPEAT = 1,
    parameter int REP_W  = $clog2(REPEAT + 1)
) (
    input  logic  clk,
    input  logic  reset,
    input  word_t s_data_in,
    input  logic  s_valid,
    output logic  s_ready,
    output word_t m_data_out_x,
    output logic  m_valid_x,
    input  logic  m_ready_x,
`ifdef VEC_TX_LAST_EN
    output logic  m_last_x,
`endif
    output logic  busy
);

    // Valid/ready: a beat moves on a rising edge with valid & ready both high; a raised
    // valid holds itself and its data until taken, and never looks at ready to decide.

    state_t            state;
    word_t             mem [X_COUNT];
    logic [ADDR_X-1:0] waddr;
    logic [ADDR_X-1:0] raddr;
    logic [REP_W-1:0]  iss_rep;
    logic [REP_W-1:0]  out_rep;
    word_t             rd_data;
    logic              rd_vld;
    logic              rd_last;
    beat_t             head;
    logic              sk_full;
    logic              sk_empty;
    logic              load_hs;
    logic              send_hs;
    logic              issue;
    logic              issue_last;
    logic              room;

    assign load_hs    = s_valid & s_ready;
    assign m_valid_x  = ~sk_empty;
    assign send_hs    = m_valid_x & m_ready_x;
    assign issue_last = (raddr == ADDR_X'(X_COUNT - 1));

    // A new read may issue only if the skid can still take it one cycle after rd_vld lands.
    assign room = sk_empty
                | (~sk_full & (~rd_vld | send_hs))
                | (sk_full & send_hs & ~rd_vld);

    always_comb begin
        issue = 1'b0;
        case (state)
            PRIME:   issue = 1'b1;
            SEND:    issue = room & (iss_rep != REP_W'(REPEAT));
            default: issue = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (load_hs) begin
            mem[waddr] <= s_data_in;
        end
        if (issue) begin
            rd_data <= mem[raddr];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= LOAD;
            s_ready <= 1'b1;
            busy    <= 1'b0;
            waddr   <= '0;
            raddr   <= '0;
            iss_rep <= '0;
            out_rep <= '0;
            rd_vld  <= 1'b0;
            rd_last <= 1'b0;
        end else begin
            rd_vld  <= issue;
            rd_last <= issue & issue_last;
            if (issue) begin
                raddr <= issue_last ? '0 : raddr + 1'b1;
                if (issue_last) begin
                    iss_rep <= iss_rep + 1'b1;
                end
            end
            case (state)
                LOAD: begin
                    if (load_hs) begin
                        busy <= 1'b1;
                        if (waddr == ADDR_X'(X_COUNT - 1)) begin
                            waddr   <= '0;
                            state   <= PRIME;
                            s_ready <= 1'b0;
                        end else begin
                            waddr <= waddr + 1'b1;
                        end
                    end
                end
                PRIME: begin
                    state <= SEND;
                end
                SEND: begin
                    // Every read has been issued by the time the last beat of the last pass leaves.
                    if (send_hs && head.last) begin
                        if (out_rep == REP_W'(REPEAT - 1)) begin
                            state   <= LOAD;
                            s_ready <= 1'b1;
                            busy    <= 1'b0;
                            out_rep <= '0;
                            iss_rep <= '0;
                            raddr   <= '0;
                        end else begin
                            out_rep <= out_rep + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

    vec_tx_skid #(
        .W($bits(beat_t))
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (rd_vld),
        .push_data ({rd_last, rd_data}),
        .pop       (send_hs),
        .head      (head),
        .full      (sk_full),
        .empty     (sk_empty)
    );

    assign m_data_out_x = sk_empty ? '0 : head.data;

`ifdef VEC_TX_LAST_EN
    assign m_last_x = ~sk_empty & head.last;
`endif

endmodule

// File: tb/tb_vec_tx_32_16.sv
// Directed bench for vec_tx_32_16 with REPEAT=1 and REPEAT=3 instances.
// Define VEC_TX_LAST_EN to build and check the m_last_x output as well.
module tb_vec_tx_32_16;

    localparam int N = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        sel;
    logic        s_valid;
    logic [15:0] s_data;
    logic        m_ready;

    logic        s_valid1, s_valid3, m_ready1, m_ready3;
    logic        s_ready1, s_ready3, m_valid1, m_valid3, busy1, busy3;
    logic [15:0] m_data1, m_data3;
    logic        s_ready_w, m_valid, busy;
    logic [15:0] m_data;
`ifdef VEC_TX_LAST_EN
    logic        m_last1, m_last3, m_last;
    assign m_last = sel ? m_last3 : m_last1;
`endif

    assign s_valid1  = s_valid & ~sel;
    assign s_valid3  = s_valid & sel;
    assign m_ready1  = m_ready & ~sel;
    assign m_ready3  = m_ready & sel;
    assign s_ready_w = sel ? s_ready3 : s_ready1;
    assign m_valid   = sel ? m_valid3 : m_valid1;
    assign m_data    = sel ? m_data3 : m_data1;
    assign busy      = sel ? busy3 : busy1;

    vec_tx_32_16 #(.REPEAT(1)) dut1 (
        .clk          (clk),
        .reset        (rst_n),
        .s_data_in    (s_data),
        .s_valid      (s_valid1),
        .s_ready      (s_ready1),
        .m_data_out_x (m_data1),
        .m_valid_x    (m_valid1),
        .m_ready_x    (m_ready1),
`ifdef VEC_TX_LAST_EN
        .m_last_x     (m_last1),
`endif
        .busy         (busy1)
    );

    vec_tx_32_16 #(.REPEAT(3)) dut3 (
        .clk          (clk),
        .reset        (rst_n),
        .s_data_in    (s_data),
        .s_valid      (s_valid3),
        .s_ready      (s_ready3),
        .m_data_out_x (m_data3),
        .m_valid_x    (m_valid3),
        .m_ready_x    (m_ready3),
`ifdef VEC_TX_LAST_EN
        .m_last_x     (m_last3),
`endif
        .busy         (busy3)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] vec [N];
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    int          last_q[$];
    int          unstable, bubbles, load_stalls, lat;
    logic        timeout, busy_seen;

    task automatic load_vec();
        load_stalls = 0;
        busy_seen   = 1'b0;
        for (int i = 0; i < N; i++) begin
            s_valid = 1'b1;
            s_data  = vec[i];
            if (!s_ready_w) load_stalls++;
            @(posedge clk);
            #1;
            if (i == 0) busy_seen = busy;
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_first();
        lat = 0;
        while (!m_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic drain(input int n, input bit rnd, input bit noise);
        int          cyc = 0;
        logic        stalled = 1'b0;
        logic [15:0] held = '0;
        logic        r;
        got_q.delete();
        last_q.delete();
        unstable = 0;
        bubbles  = 0;
        timeout  = 1'b0;
        while (got_q.size() < n) begin
            if (cyc >= 2000) begin
                timeout = 1'b1;
                break;
            end
            r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (noise) begin
                s_valid = 1'b1;
                s_data  = 16'h7FFF;
            end
            if (!m_valid) begin
                bubbles++;
                if (stalled) unstable++;
            end else if (stalled && m_data !== held) begin
                unstable++;
            end
            m_ready = r;
            if (m_valid && r) begin
                got_q.push_back(m_data);
`ifdef VEC_TX_LAST_EN
                if (m_last) last_q.push_back(got_q.size() - 1);
`endif
                stalled = 1'b0;
            end else if (m_valid) begin
                stalled = 1'b1;
                held    = m_data;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        m_ready = 1'b0;
        s_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (s_ready_w !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready: got %b want 1", s_ready_w); end
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
        n_checks++; if (m_data !== 16'h0) begin n_fail++; $display("FAIL reset_m_data: got %h want 0000", m_data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (m_valid3 !== 1'b0 || s_ready3 !== 1'b1) begin n_fail++; $display("FAIL reset_dut3: valid %b ready %b want 0 1", m_valid3, s_ready3); end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if (s_ready_w !== 1'b1 || m_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: ready %b valid %b want 1 0", s_ready_w, m_valid); end
    endtask

    task automatic test_basic();
        exp_q.delete();
        for (int i = 0; i < N; i++) begin vec[i] = 16'(i); exp_q.push_back(16'(i)); end
        load_vec();
        n_checks++; if (load_stalls != 0) begin n_fail++; $display("FAIL basic_load_stalls: got %0d want 0", load_stalls); end
        n_checks++; if (busy_seen !== 1'b1) begin n_fail++; $display("FAIL basic_busy_rise: got %b want 1", busy_seen); end
        wait_first();
        n_checks++; if (lat != 2) begin n_fail++; $display("FAIL basic_latency: got %0d want 2", lat); end
        drain(N, 1'b0, 1'b0);
        n_checks++; if (timeout) begin n_fail++; $display("FAIL basic_timeout: got %0d words want %0d", got_q.size(), N); end
        n_checks++; if (bubbles != 0) begin n_fail++; $display("FAIL basic_bubbles: got %0d want 0", bubbles); end
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (i >= got_q.size()) begin n_fail++; $display("FAIL basic_word[%0d]: missing want %h", i, exp_q[i]); end
            else if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL basic_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        n_checks++; if (m_valid !== 1'b0 || busy !== 1'b0 || s_ready_w !== 1'b1) begin n_fail++; $display("FAIL basic_done: valid %b busy %b ready %b want 0 0 1", m_valid, busy, s_ready_w); end
        n_checks++; if (m_data !== 16'h0) begin n_fail++; $display("FAIL basic_idle_data: got %h want 0000", m_data); end
`ifdef VEC_TX_LAST_EN
        n_checks++; if (last_q.size() != 1 || last_q[0] != 31) begin n_fail++; $display("FAIL basic_last: got %0d marks want one at 31", last_q.size()); end
`endif
    endtask

    task automatic test_backpressure();
        exp_q.delete();
        for (int i = 0; i < N; i++) begin vec[i] = 16'(i); exp_q.push_back(16'(i)); end
        load_vec();
        wait_first();
        n_checks++; if (lat != 2) begin n_fail++; $display("FAIL bp_latency: got %0d want 2", lat); end
        drain(N, 1'b1, 1'b0);
        n_checks++; if (timeout) begin n_fail++; $display("FAIL bp_timeout: got %0d words want %0d", got_q.size(), N); end
        n_checks++; if (unstable != 0) begin n_fail++; $display("FAIL bp_stability: got %0d violations want 0", unstable); end
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (i >= got_q.size()) begin n_fail++; $display("FAIL bp_word[%0d]: missing want %h", i, exp_q[i]); end
            else if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        n_checks++; if (m_valid !== 1'b0 || busy !== 1'b0 || s_ready_w !== 1'b1) begin n_fail++; $display("FAIL bp_done: valid %b busy %b ready %b want 0 0 1", m_valid, busy, s_ready_w); end
    endtask

    task automatic test_repeat();
        sel = 1'b1;
        vec[0] = 16'hFF9F;
        vec[1] = 16'hFF7E;
        vec[2] = 16'h0089;
        for (int i = 3; i < N; i++) vec[i] = 16'(i * 977) - 16'd5000;
        exp_q.delete();
        for (int r = 0; r < 3; r++) for (int i = 0; i < N; i++) exp_q.push_back(vec[i]);
        load_vec();
        wait_first();
        n_checks++; if (lat != 2) begin n_fail++; $display("FAIL rep_latency: got %0d want 2", lat); end
        drain(3 * N, 1'b0, 1'b0);
        n_checks++; if (timeout) begin n_fail++; $display("FAIL rep_timeout: got %0d words want %0d", got_q.size(), 3 * N); end
        n_checks++; if (bubbles != 0) begin n_fail++; $display("FAIL rep_bubbles: got %0d want 0", bubbles); end
        for (int i = 0; i < 3 * N; i++) begin
            n_checks++;
            if (i >= got_q.size()) begin n_fail++; $display("FAIL rep_word[%0d]: missing want %h", i, exp_q[i]); end
            else if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rep_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        n_checks++; if (m_valid !== 1'b0 || busy !== 1'b0 || s_ready_w !== 1'b1) begin n_fail++; $display("FAIL rep_done: valid %b busy %b ready %b want 0 0 1", m_valid, busy, s_ready_w); end
`ifdef VEC_TX_LAST_EN
        n_checks++;
        if (last_q.size() != 3 || last_q[0] != 31 || last_q[1] != 63 || last_q[2] != 95) begin
            n_fail++; $display("FAIL rep_last: got %0d marks want 31,63,95", last_q.size());
        end
`endif
        sel = 1'b0;
    endtask

    task automatic test_ignore();
        exp_q.delete();
        for (int i = 0; i < N; i++) begin vec[i] = 16'h1000 + 16'(i); exp_q.push_back(vec[i]); end
        load_vec();
        wait_first();
        drain(N, 1'b1, 1'b1);
        n_checks++; if (timeout) begin n_fail++; $display("FAIL ign_timeout: got %0d words want %0d", got_q.size(), N); end
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (i >= got_q.size()) begin n_fail++; $display("FAIL ign_word[%0d]: missing want %h", i, exp_q[i]); end
            else if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ign_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        n_checks++; if (s_ready_w !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL ign_done: ready %b busy %b want 1 0", s_ready_w, busy); end
        exp_q.delete();
        for (int i = 0; i < N; i++) begin vec[i] = 16'h2000 + 16'(i); exp_q.push_back(vec[i]); end
        load_vec();
        wait_first();
        drain(N, 1'b0, 1'b0);
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (i >= got_q.size()) begin n_fail++; $display("FAIL ign_reload[%0d]: missing want %h", i, exp_q[i]); end
            else if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ign_reload[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < N; i++) vec[i] = 16'h0500 + 16'(i);
        load_vec();
        wait_first();
        drain(10, 1'b0, 1'b0);
        n_checks++; if (m_valid !== 1'b1 || m_data !== 16'h050A) begin n_fail++; $display("FAIL mid_word10: valid %b data %h want 1 050a", m_valid, m_data); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (m_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_async_drop: valid %b busy %b want 0 0", m_valid, busy); end
        n_checks++; if (m_data !== 16'h0) begin n_fail++; $display("FAIL mid_async_data: got %h want 0000", m_data); end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if (s_ready_w !== 1'b1 || m_valid !== 1'b0) begin n_fail++; $display("FAIL mid_release: ready %b valid %b want 1 0", s_ready_w, m_valid); end
        exp_q.delete();
        for (int i = 0; i < N; i++) begin vec[i] = 16'(100 + i); exp_q.push_back(vec[i]); end
        load_vec();
        wait_first();
        n_checks++; if (lat != 2) begin n_fail++; $display("FAIL mid_latency: got %0d want 2", lat); end
        drain(N, 1'b0, 1'b0);
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (i >= got_q.size()) begin n_fail++; $display("FAIL mid_word[%0d]: missing want %h", i, exp_q[i]); end
            else if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL mid_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < N; i++) vec[i] = 16'hC000 + 16'(i);
        load_vec();
        wait_first();
        drain(N, 1'b0, 1'b0);
        n_checks++; if (s_ready_w !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_rise: got %b want 1", s_ready_w); end
        exp_q.delete();
        for (int i = 0; i < N; i++) begin vec[i] = 16'h0400 + 16'(i * 3); exp_q.push_back(vec[i]); end
        load_vec();
        n_checks++; if (load_stalls != 0) begin n_fail++; $display("FAIL b2b_load_stalls: got %0d want 0", load_stalls); end
        wait_first();
        n_checks++; if (lat != 2) begin n_fail++; $display("FAIL b2b_latency: got %0d want 2", lat); end
        drain(N, 1'b0, 1'b0);
        n_checks++; if (bubbles != 0) begin n_fail++; $display("FAIL b2b_bubbles: got %0d want 0", bubbles); end
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (i >= got_q.size()) begin n_fail++; $display("FAIL b2b_word[%0d]: missing want %h", i, exp_q[i]); end
            else if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        n_checks++; if (m_valid !== 1'b0 || busy !== 1'b0 || s_ready_w !== 1'b1) begin n_fail++; $display("FAIL b2b_done: valid %b busy %b ready %b want 0 0 1", m_valid, busy, s_ready_w); end
    endtask

    initial begin
        sel     = 1'b0;
        rst_n   = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_repeat();
        test_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
